// File: rtl/ram_queue_if.sv
// Handshake/status bundle for ram_queue_ctrl; ovf/udf exist only when
// QUEUE_ERR_FLAGS_EN is defined.
interface ram_queue_if #(
  parameter int WIDTH = 6,
  parameter int AW    = 4
);
  logic             push;
  logic [WIDTH-1:0] wr_data;
  logic             pop;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
`ifdef QUEUE_ERR_FLAGS_EN
  logic             ovf;
  logic             udf;
`endif

  modport master (
    output push, wr_data, pop,
    input  rd_data, rd_valid, full, empty, count
`ifdef QUEUE_ERR_FLAGS_EN
    , input ovf, udf
`endif
  );

  modport slave (
    input  push, wr_data, pop,
    output rd_data, rd_valid, full, empty, count
`ifdef QUEUE_ERR_FLAGS_EN
    , output ovf, udf
`endif
  );
endinterface

// File: rtl/ram_queue_ctrl.sv
// Register-array FIFO for encoder key codes; zero ("no key") writes are dropped.
// Optional sticky ovf/udf error flags are built when QUEUE_ERR_FLAGS_EN is defined.
module ram_queue_ctrl #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_queue_if.slave   q
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             full;
  logic             empty;
  logic             push_acc;
  logic             pop_acc;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // No bypass: a pop on empty is rejected even alongside a push, and a push
  // at full only lands when the same-cycle pop frees a slot.
  assign pop_acc  = q.pop && !empty;
  assign push_acc = q.push && (q.wr_data != '0) && (!full || pop_acc);

  // NOTE: the storage array is deliberately left out of reset; entries are
  // only meaningful once pointers say so, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= q.wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_acc;
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_q <= mem[rd_ptr];
      end
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef QUEUE_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (q.push && (q.wr_data != '0) && full && !pop_acc) ovf_q <= 1'b1;
      if (q.pop && empty)                                  udf_q <= 1'b1;
    end
  end

  assign q.ovf = ovf_q;
  assign q.udf = udf_q;
`endif

  assign q.rd_data  = rd_data_q;
  assign q.rd_valid = rd_valid_q;
  assign q.full     = full;
  assign q.empty    = empty;
  assign q.count    = count_q;
endmodule

// File: doc/ram_queue_ctrl.md
RAM_QUEUE_CTRL -- requirements
Module: ram_queue_ctrl

Interface
REQ-001 Parameter WIDTH, default 6, SHALL set the data width; it matches the 6-bit code produced by the key-to-data encoder.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of entries and SHALL be a power of two, >= 2.
REQ-003 Parameter AW, default 4, SHALL equal log2(DEPTH) and set the pointer width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 push  input  1  SHALL request a write of wr_data this cycle.
REQ-007 wr_data  input  WIDTH  SHALL carry the write data, sampled when push=1.
REQ-008 pop  input  1  SHALL request a read of the oldest entry this cycle.
REQ-009 rd_data  output  WIDTH  SHALL be the registered data of the last accepted pop.
REQ-010 rd_valid  output  1  SHALL pulse for one cycle when rd_data is updated.
REQ-011 full  output  1  SHALL be high when count==DEPTH.
REQ-012 empty  output  1  SHALL be high when count==0.
REQ-013 count  output  AW+1  SHALL give the number of stored entries, 0..DEPTH.
REQ-014 ovf  output  1  SHALL be a sticky overflow flag; present only with QUEUE_ERR_FLAGS_EN.
REQ-015 udf  output  1  SHALL be a sticky underflow flag; present only with QUEUE_ERR_FLAGS_EN.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH register array, written only on an accepted push; array contents SHALL NOT be reset.
REQ-017 A push SHALL be accepted when push=1 and wr_data!=0 and one of these holds: (!full) or (full and the pop is accepted).
REQ-018 A push with wr_data==0 SHALL be dropped silently: no write and no pointer or count change. Zero is the encoder's "no key" code.
REQ-019 A pop SHALL be accepted when pop=1 and !empty; there is no bypass, so a pop on empty SHALL be rejected even if a push occurs in the same cycle.
REQ-020 An accepted push SHALL write mem[wr_ptr] and increment wr_ptr modulo DEPTH; pointer wrap-around SHALL be natural AW-bit wrap.
REQ-021 An accepted pop SHALL load rd_data from mem[rd_ptr] on the same edge, increment rd_ptr modulo DEPTH, and assert rd_valid for exactly the next cycle. Read latency is 1 cycle.
REQ-022 rd_data SHALL hold its value when no pop is accepted.
REQ-023 count SHALL change as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-024 full and empty SHALL be registered or derived from registered count, and SHALL be glitch-free in the cycle after the edge.
REQ-025 Simultaneous accepted push and pop at full SHALL leave count=DEPTH and full=1, and SHALL return the oldest entry.
REQ-026 Order SHALL be strict FIFO across any number of wraps.

Reset
REQ-027 While rst_n=0: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0, ovf=0, udf=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries immediately; the first accepted push after release SHALL be read first.

Configuration
REQ-029 With QUEUE_ERR_FLAGS_EN defined, ovf SHALL set on push=1 with nonzero wr_data that is rejected because full=1 with no accepted pop, udf SHALL set on pop=1 when empty=1, and both SHALL clear only by reset.
REQ-030 Without QUEUE_ERR_FLAGS_EN, the ovf and udf ports and their logic SHALL be absent, and rejected requests SHALL remain silent.

Verification
REQ-031 Reset, then push 11,22,33, then pop x3: rd_data = 11,22,33, each with a 1-cycle rd_valid pulse; final empty=1, count=0.
REQ-032 Push 16 nonzero values: full=1, count=16; a 17th push leaves contents unchanged, and ovf=1 when the macro is defined.
REQ-033 At full, push 55 and pop together: rd_data = oldest entry, count stays 16, and 55 is read last after 15 further pops.
REQ-034 Push wr_data=0 three times: count stays 0 and empty=1; pop on empty: rd_valid=0, and udf=1 when the macro is defined.
REQ-035 Run 40 push/pop pairs through the wrap: output sequence equals input sequence; with 5 entries queued, assert rst_n=0 mid-run: count=0 and empty=1 immediately.
